// File: rtl/retx_req_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : retx_req_sched                                               |
// | Description : MoldUDP64 retransmission request scheduler. Captures         |
// |               same-session and session-range misses into a small FIFO     |
// |               and splits each one into {session, seq, count} requests     |
// |               issued over a valid/ready handshake with optional spacing.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module retx_req_sched #(
   parameter int unsigned SEQ_NUM_W   = 64,
   parameter int unsigned SID_W       = 80,
   parameter int unsigned ML_W        = 16,
   parameter int unsigned REQ_MAX     = 1024,
   parameter int unsigned SID_REQ_MAX = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned REQ_GAP     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 miss_seq_v_i,
   input  logic [SID_W-1:0]     miss_seq_sid_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_cnt_i,
   input  logic                 miss_sid_v_i,
   input  logic [SID_W-1:0]     miss_sid_start_i,
   input  logic [SEQ_NUM_W-1:0] miss_sid_seq_start_i,
   input  logic [SID_W-1:0]     miss_sid_cnt_i,
   output logic                 req_v_o,
   input  logic                 req_ready_i,
   output logic [SID_W-1:0]     req_sid_o,
   output logic [SEQ_NUM_W-1:0] req_seq_num_o,
   output logic [ML_W-1:0]      req_cnt_o,
   output logic                 busy_o,
   output logic                 ovf_o
);

   // The FIFO count field holds either a sequence count or a session count.
   localparam int unsigned CNT_W = (SID_W > SEQ_NUM_W) ? SID_W : SEQ_NUM_W;
   localparam int unsigned AW    = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] REQ_MAX_C  = CNT_W'(REQ_MAX);
   localparam logic [CNT_W-1:0] SID_MAX_C  = CNT_W'(SID_REQ_MAX);
   localparam logic [ML_W-1:0]  REQ_MAX_ML = ML_W'(REQ_MAX);
   localparam logic [15:0]      GAP_LOAD   = (REQ_GAP > 0) ? 16'(REQ_GAP - 1) : 16'd0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEQ  = 2'd1;
   localparam logic [1:0] S_SID  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   // Miss FIFO storage, one field per array
   logic                 fifo_type [DEPTH];
   logic [SID_W-1:0]     fifo_sid  [DEPTH];
   logic [SEQ_NUM_W-1:0] fifo_seq  [DEPTH];
   logic [CNT_W-1:0]     fifo_cnt  [DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;

   logic                 empty;
   logic                 full;
   logic                 head_type;
   logic [SID_W-1:0]     head_sid;
   logic [SEQ_NUM_W-1:0] head_seq;
   logic [CNT_W-1:0]     head_cnt;

   logic                 want_sid;
   logic                 want_seq;
   logic                 collide;
   logic                 pop;
   logic                 push;
   logic                 ovf_set;
   logic [SID_W-1:0]     push_sid;
   logic [SEQ_NUM_W-1:0] push_seq;
   logic [CNT_W-1:0]     push_cnt;

   // Working registers for the entry being issued
   logic [1:0]           state;
   logic [1:0]           state_nx;
   logic [SID_W-1:0]     cur_sid;
   logic [SEQ_NUM_W-1:0] cur_seq;
   logic [CNT_W-1:0]     rem;
   logic                 in_sid;
   logic [15:0]          gap_cnt;
   logic                 ovf;

   logic                 issuing;
   logic                 hs;
   logic [ML_W-1:0]      chunk;
   logic [CNT_W-1:0]     rem_after_seq;
   logic [CNT_W-1:0]     rem_after_sid;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_type = fifo_type[rd_ptr[AW-1:0]];
   assign head_sid  = fifo_sid[rd_ptr[AW-1:0]];
   assign head_seq  = fifo_seq[rd_ptr[AW-1:0]];
   assign head_cnt  = fifo_cnt[rd_ptr[AW-1:0]];

   // A simultaneous pair is illegal upstream; the session-range miss wins.
   assign collide  = miss_seq_v_i & miss_sid_v_i;
   assign want_sid = miss_sid_v_i & (miss_sid_cnt_i != '0);
   assign want_seq = miss_seq_v_i & ~miss_sid_v_i & (miss_seq_cnt_i != '0);
   assign pop      = (state == S_IDLE) & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push     = (want_sid | want_seq) & (~full | pop);
   assign ovf_set  = ((want_sid | want_seq) & full & ~pop) | collide |
                     (pop & head_type & (head_cnt > SID_MAX_C));

   assign push_sid = miss_sid_v_i ? miss_sid_start_i     : miss_seq_sid_i;
   assign push_seq = miss_sid_v_i ? miss_sid_seq_start_i : miss_seq_start_i;
   assign push_cnt = miss_sid_v_i ? CNT_W'(miss_sid_cnt_i) : CNT_W'(miss_seq_cnt_i);

   assign issuing       = (state == S_SEQ) | (state == S_SID);
   assign hs            = issuing & req_ready_i;
   assign chunk         = (rem > REQ_MAX_C) ? REQ_MAX_ML : rem[ML_W-1:0];
   assign rem_after_seq = rem - CNT_W'(chunk);
   assign rem_after_sid = rem - CNT_W'(1);

   assign busy_o = ~empty | (state != S_IDLE);
   assign ovf_o  = ovf;

   // FIFO storage write; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_type[wr_ptr[AW-1:0]] <= miss_sid_v_i;
         fifo_sid[wr_ptr[AW-1:0]]  <= push_sid;
         fifo_seq[wr_ptr[AW-1:0]]  <= push_seq;
         fifo_cnt[wr_ptr[AW-1:0]]  <= push_cnt;
      end
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (ovf_set) begin
            ovf <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               state_nx = head_type ? S_SID : S_SEQ;
            end
         end
         S_SEQ: begin
            if (hs) begin
               if (REQ_GAP > 0) begin
                  state_nx = S_GAP;
               end else if (rem_after_seq == '0) begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_SID: begin
            if (hs) begin
               if (REQ_GAP > 0) begin
                  state_nx = S_GAP;
               end else if (rem_after_sid == '0) begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == 16'd0) begin
               if (rem == '0) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx = in_sid ? S_SID : S_SEQ;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Working registers: load on pop, advance on each handshake, count the gap.
   // Session entries are clipped to SID_REQ_MAX sessions at load time.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_sid <= '0;
         cur_seq <= '0;
         rem     <= '0;
         in_sid  <= 1'b0;
         gap_cnt <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  cur_sid <= head_sid;
                  cur_seq <= head_seq;
                  in_sid  <= head_type;
                  rem     <= (head_type && (head_cnt > SID_MAX_C)) ? SID_MAX_C : head_cnt;
               end
            end
            S_SEQ: begin
               if (hs) begin
                  cur_seq <= cur_seq + SEQ_NUM_W'(chunk);
                  rem     <= rem_after_seq;
                  gap_cnt <= GAP_LOAD;
               end
            end
            S_SID: begin
               if (hs) begin
                  cur_sid <= cur_sid + SID_W'(1);
                  cur_seq <= SEQ_NUM_W'(1);
                  rem     <= rem_after_sid;
                  gap_cnt <= GAP_LOAD;
               end
            end
            S_GAP: begin
               if (gap_cnt != 16'd0) begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Request outputs, driven to zero whenever no request is offered
   always_comb begin
      req_v_o       = 1'b0;
      req_sid_o     = '0;
      req_seq_num_o = '0;
      req_cnt_o     = '0;
      if (issuing) begin
         req_v_o       = 1'b1;
         req_sid_o     = cur_sid;
         req_seq_num_o = cur_seq;
         req_cnt_o     = (state == S_SEQ) ? chunk : REQ_MAX_ML;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_retx_req_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_retx_req_sched                                            |
// | Description : Self-checking bench for retx_req_sched with a queue-based    |
// |               request model, directed scenarios and random misses.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_retx_req_sched;

   localparam int REQ_MAX     = 1024;
   localparam int SID_REQ_MAX = 8;
   localparam int DEPTH       = 4;
   localparam int GAP         = 3;

   typedef struct packed {
      logic [79:0] sid;
      logic [63:0] seq;
      logic [15:0] cnt;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        miss_seq_v_i;
   logic [79:0] miss_seq_sid_i;
   logic [63:0] miss_seq_start_i;
   logic [63:0] miss_seq_cnt_i;
   logic        miss_sid_v_i;
   logic [79:0] miss_sid_start_i;
   logic [63:0] miss_sid_seq_start_i;
   logic [79:0] miss_sid_cnt_i;
   logic        req_ready_i;

   logic        a_v, a_busy, a_ovf;
   logic [79:0] a_sid;
   logic [63:0] a_seq;
   logic [15:0] a_cnt;
   logic        g_v, g_busy, g_ovf;
   logic [79:0] g_sid;
   logic [63:0] g_seq;
   logic [15:0] g_cnt;

   // Monitored view: main instance (no gap) or throttled instance
   logic        sel;
   logic        m_v, m_busy, m_ovf;
   logic [79:0] m_sid;
   logic [63:0] m_seq;
   logic [15:0] m_cnt;

   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          last_hs = -1;
   int          hs_diff = 0;
   bit          pend = 1'b0;
   logic [79:0] p_sid;
   logic [63:0] p_seq;
   logic [15:0] p_cnt;
   req_t        exp_q[$];

   always #5 clk = ~clk;

   always_comb begin
      m_v    = sel ? g_v    : a_v;
      m_busy = sel ? g_busy : a_busy;
      m_ovf  = sel ? g_ovf  : a_ovf;
      m_sid  = sel ? g_sid  : a_sid;
      m_seq  = sel ? g_seq  : a_seq;
      m_cnt  = sel ? g_cnt  : a_cnt;
   end

   retx_req_sched #(.REQ_MAX(REQ_MAX), .SID_REQ_MAX(SID_REQ_MAX), .DEPTH(DEPTH), .REQ_GAP(0)) dut (
      .clk(clk), .reset(reset),
      .miss_seq_v_i(miss_seq_v_i), .miss_seq_sid_i(miss_seq_sid_i),
      .miss_seq_start_i(miss_seq_start_i), .miss_seq_cnt_i(miss_seq_cnt_i),
      .miss_sid_v_i(miss_sid_v_i), .miss_sid_start_i(miss_sid_start_i),
      .miss_sid_seq_start_i(miss_sid_seq_start_i), .miss_sid_cnt_i(miss_sid_cnt_i),
      .req_v_o(a_v), .req_ready_i(req_ready_i), .req_sid_o(a_sid),
      .req_seq_num_o(a_seq), .req_cnt_o(a_cnt), .busy_o(a_busy), .ovf_o(a_ovf)
   );

   retx_req_sched #(.REQ_MAX(REQ_MAX), .SID_REQ_MAX(SID_REQ_MAX), .DEPTH(DEPTH), .REQ_GAP(GAP)) dut_gap (
      .clk(clk), .reset(reset),
      .miss_seq_v_i(miss_seq_v_i), .miss_seq_sid_i(miss_seq_sid_i),
      .miss_seq_start_i(miss_seq_start_i), .miss_seq_cnt_i(miss_seq_cnt_i),
      .miss_sid_v_i(miss_sid_v_i), .miss_sid_start_i(miss_sid_start_i),
      .miss_sid_seq_start_i(miss_sid_seq_start_i), .miss_sid_cnt_i(miss_sid_cnt_i),
      .req_v_o(g_v), .req_ready_i(req_ready_i), .req_sid_o(g_sid),
      .req_seq_num_o(g_seq), .req_cnt_o(g_cnt), .busy_o(g_busy), .ovf_o(g_ovf)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Model: a sequence miss becomes consecutive chunks of at most REQ_MAX
   function automatic void model_seq(input logic [79:0] sid, input logic [63:0] start,
                                     input logic [63:0] n);
      req_t        r;
      logic [63:0] s;
      logic [63:0] left;
      s    = start;
      left = n;
      while (left != 64'd0) begin
         r.sid = sid;
         r.seq = s;
         r.cnt = (left > 64'(REQ_MAX)) ? 16'(REQ_MAX) : left[15:0];
         exp_q.push_back(r);
         s    = s + 64'(r.cnt);
         left = left - 64'(r.cnt);
      end
   endfunction

   // Model: one full-size request per session, at most SID_REQ_MAX sessions
   function automatic void model_sid(input logic [79:0] sid, input logic [63:0] seq,
                                     input logic [79:0] n);
      req_t r;
      int   k;
      k = (n > 80'(SID_REQ_MAX)) ? SID_REQ_MAX : int'(n);
      for (int i = 0; i < k; i++) begin
         r.sid = sid + 80'(i);
         r.seq = (i == 0) ? seq : 64'd1;
         r.cnt = 16'(REQ_MAX);
         exp_q.push_back(r);
      end
   endfunction

   // One clock: set ready at the falling edge, then score the handshake it implies
   task automatic cycle(input bit rdy);
      req_t e;
      @(negedge clk);
      req_ready_i = rdy;
      cyc++;
      if (reset) begin
         pend = 1'b0;
         return;
      end
      if (pend) begin
         check("hold_v", m_v, 1'b1);
         check("hold_sid", m_sid, p_sid);
         check("hold_seq", m_seq, p_seq);
         check("hold_cnt", m_cnt, p_cnt);
      end
      if (m_v && rdy) begin
         if (exp_q.size() == 0) begin
            check("spurious_req", m_v, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("req_sid", m_sid, e.sid);
            check("req_seq", m_seq, e.seq);
            check("req_cnt", m_cnt, e.cnt);
         end
         if (last_hs >= 0) begin
            hs_diff = cyc - last_hs;
            if (sel) check("gap_spacing", 1'(hs_diff >= GAP + 1), 1'b1);
         end
         last_hs = cyc;
      end
      pend  = m_v && !rdy;
      p_sid = m_sid;
      p_seq = m_seq;
      p_cnt = m_cnt;
   endtask

   task automatic push_seq(input logic [79:0] sid, input logic [63:0] st, input logic [63:0] n,
                           input bit rdy, input bit accepted);
      miss_seq_v_i     = 1'b1;
      miss_seq_sid_i   = sid;
      miss_seq_start_i = st;
      miss_seq_cnt_i   = n;
      if (accepted) model_seq(sid, st, n);
      cycle(rdy);
      miss_seq_v_i = 1'b0;
   endtask

   task automatic push_sid(input logic [79:0] sid, input logic [63:0] st, input logic [79:0] n,
                           input bit rdy);
      miss_sid_v_i         = 1'b1;
      miss_sid_start_i     = sid;
      miss_sid_seq_start_i = st;
      miss_sid_cnt_i       = n;
      model_sid(sid, st, n);
      cycle(rdy);
      miss_sid_v_i = 1'b0;
   endtask

   task automatic drain(input int pct, input int maxc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_busy) && n < maxc) begin
         cycle($urandom_range(99, 0) < pct);
         n++;
      end
      check("drain_timeout", 1'(n < maxc), 1'b1);
      check("model_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      miss_seq_v_i = 1'b0;
      miss_sid_v_i = 1'b0;
      cycle(1'b0);
      reset = 1'b0;
      exp_q.delete();
      pend    = 1'b0;
      last_hs = -1;
   endtask

   initial begin
      logic [95:0] rnd;
      reset                = 1'b1;
      sel                  = 1'b0;
      req_ready_i          = 1'b0;
      miss_seq_v_i         = 1'b0;
      miss_seq_sid_i       = '0;
      miss_seq_start_i     = '0;
      miss_seq_cnt_i       = '0;
      miss_sid_v_i         = 1'b0;
      miss_sid_start_i     = '0;
      miss_sid_seq_start_i = '0;
      miss_sid_cnt_i       = '0;

      // Reset state
      do_reset();
      check("rst_v", m_v, 1'b0);
      check("rst_busy", m_busy, 1'b0);
      check("rst_ovf", m_ovf, 1'b0);
      check("rst_sid", m_sid, 80'd0);
      check("rst_seq", m_seq, 64'd0);
      check("rst_cnt", m_cnt, 16'd0);

      // Single miss: latency 2, busy drops after the handshake
      push_seq(80'd5, 64'd100, 64'd10, 1'b1, 1'b1);
      check("lat1_v", m_v, 1'b0);
      check("lat1_busy", m_busy, 1'b1);
      cycle(1'b1);
      check("lat2_v", m_v, 1'b1);
      cycle(1'b1);
      cycle(1'b1);
      check("busy_after", m_busy, 1'b0);
      check("single_done", exp_q.size(), 0);

      // Split with backpressure
      push_seq(80'd0, 64'd0, 64'd2500, 1'b0, 1'b1);
      drain(50, 300);
      check("split_ovf", m_ovf, 1'b0);

      // Back-to-back chunks with ready held high
      push_seq(80'd2, 64'd77, 64'd3000, 1'b1, 1'b1);
      drain(100, 100);
      check("b2b_spacing", hs_diff, 1);

      // REQ_MAX boundaries, two misses queued back to back
      push_seq(80'd3, 64'd10, 64'd1024, 1'b1, 1'b1);
      push_seq(80'd4, 64'd20, 64'd1025, 1'b1, 1'b1);
      drain(70, 200);

      // Sequence wrap
      push_seq(80'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 1'b1, 1'b1);
      drain(100, 50);
      check("wrap_cur_seq", dut.cur_seq, 64'd3);

      // Session-range misses, then truncation beyond SID_REQ_MAX
      push_sid(80'd7, 64'd40, 80'd3, 1'b1);
      drain(70, 100);
      check("sid3_ovf", m_ovf, 1'b0);
      push_sid(80'd100, 64'd9, 80'd12, 1'b1);
      drain(70, 200);
      check("sid12_ovf", m_ovf, 1'b1);

      // Zero-count misses are discarded silently
      do_reset();
      push_seq(80'd1, 64'd1, 64'd0, 1'b1, 1'b0);
      push_sid(80'd1, 64'd1, 80'd0, 1'b1);
      check("zero_busy", m_busy, 1'b0);
      check("zero_ovf", m_ovf, 1'b0);

      // Fill the FIFO behind a stalled request, push into a full FIFO on a pop, then overflow
      push_seq(80'd10, 64'd1, 64'd1, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) push_seq(80'(11 + i), 64'd1, 64'd2, 1'b0, 1'b1);
      check("full_no_ovf", m_ovf, 1'b0);
      cycle(1'b1);
      cycle(1'b0);
      push_seq(80'd20, 64'd5, 64'd3, 1'b0, 1'b1);
      check("full_pop_push_ovf", m_ovf, 1'b0);
      push_seq(80'd21, 64'd5, 64'd3, 1'b0, 1'b0);
      cycle(1'b0);
      check("overflow_ovf", m_ovf, 1'b1);
      drain(100, 100);

      // Collision: only the session entry is written
      do_reset();
      miss_seq_v_i     = 1'b1;
      miss_seq_sid_i   = 80'd1;
      miss_seq_start_i = 64'd5;
      miss_seq_cnt_i   = 64'd3;
      push_sid(80'd20, 64'd9, 80'd2, 1'b1);
      miss_seq_v_i = 1'b0;
      drain(100, 50);
      check("collide_ovf", m_ovf, 1'b1);

      // Random misses against the model
      do_reset();
      for (int i = 0; i < 30; i++) begin
         rnd = {$urandom, $urandom, $urandom};
         if ($urandom_range(3, 0) == 0) begin
            push_sid(rnd[79:0], {$urandom, $urandom}, 80'($urandom_range(12, 1)),
                     1'($urandom_range(1, 0)));
         end else if ($urandom_range(3, 0) == 0) begin
            push_seq(rnd[79:0], 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(4095, 0)),
                     64'($urandom_range(3500, 1)), 1'($urandom_range(1, 0)), 1'b1);
         end else begin
            push_seq(rnd[79:0], {$urandom, $urandom}, 64'($urandom_range(3500, 1)),
                     1'($urandom_range(1, 0)), 1'b1);
         end
         drain(60, 2000);
      end

      // Throttled instance: request spacing
      sel = 1'b1;
      do_reset();
      push_seq(80'd3, 64'd500, 64'd5000, 1'b1, 1'b1);
      drain(100, 400);
      check("gap_ovf", m_ovf, 1'b0);
      push_sid(80'd30, 64'd7, 80'd3, 1'b1);
      drain(70, 400);

      // Reset in the middle of a split aborts everything including ovf
      push_sid(80'd40, 64'd1, 80'd12, 1'b1);
      drain(100, 400);
      check("pre_rst_ovf", m_ovf, 1'b1);
      push_seq(80'd1, 64'd0, 64'd5000, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1);
      check("mid_split_busy", m_busy, 1'b1);
      reset = 1'b1;
      cycle(1'b0);
      check("mid_rst_v", m_v, 1'b0);
      check("mid_rst_busy", m_busy, 1'b0);
      check("mid_rst_ovf", m_ovf, 1'b0);
      reset = 1'b0;
      exp_q.delete();
      pend    = 1'b0;
      last_hs = -1;
      cycle(1'b1);
      cycle(1'b1);
      check("post_rst_v", m_v, 1'b0);
      check("post_rst_busy", m_busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
